// File: rtl/instr_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory read port, decoder
// handshake and branch redirect. The fetch block uses the master modport;
// the memory/decoder side uses the slave modport.
interface instr_fetch_if #(
    parameter int PC_W = 10,
    parameter int IW   = 9
);
    logic            imem_en;
    logic [PC_W-1:0] imem_addr;
    logic [IW-1:0]   imem_rdata;
    logic [IW-1:0]   instr;
    logic [PC_W-1:0] instr_pc;
    logic            instr_valid;
    logic            decode_ready;
    logic            redirect_valid;
    logic [PC_W-1:0] redirect_target;

    modport master (
        output imem_en, imem_addr, instr, instr_pc, instr_valid,
        input  imem_rdata, decode_ready, redirect_valid, redirect_target
    );

    modport slave (
        input  imem_en, imem_addr, instr, instr_pc, instr_valid,
        output imem_rdata, decode_ready, redirect_valid, redirect_target
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage in front of a synchronous ROM.
// Issues one address per cycle, presents the returned word to the decoder,
// stalls by re-issuing, flushes on redirect and halts after last_pc.
// Optional feature: define FETCH_PERF_CNT_EN to enable the saturating
// accepted-instruction counter on instr_count (otherwise tied to 0).
//
// state | meaning
// IDLE  | out of reset, waiting for start
// RUN   | fetching; imem_en asserted every cycle
// HALT  | last_pc accepted; done=1 until the next start
module instr_fetch #(
    parameter int PC_W = 10,
    parameter int IW   = 9
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [PC_W-1:0] last_pc,
    output logic            done,
    output logic [15:0]     instr_count,
    instr_fetch_if.master   bus
);
    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    state_t          state, state_nxt;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] issued_addr;
    logic [PC_W-1:0] fetch_addr;
    logic            inflight;
    logic            in_run;
    logic            launch;
    logic            redirect;
    logic            accept;
    logic            stall;
    logic            at_last;

    // Handshake decode and the address issued this cycle. A stall re-issues
    // the word on display so the ROM keeps returning it; an acceptance
    // issues the successor straight away for one-per-cycle throughput.
    always_comb begin
        in_run          = (state == RUN);
        launch          = !in_run && start;
        redirect        = in_run && bus.redirect_valid;
        bus.instr_valid = in_run && inflight && !bus.redirect_valid;
        accept          = bus.instr_valid && bus.decode_ready;
        stall           = bus.instr_valid && !bus.decode_ready;
        at_last         = accept && (issued_addr == last_pc);
        fetch_addr      = pc;
        if (stall)
            fetch_addr = issued_addr;
        else if (accept)
            fetch_addr = issued_addr + PC_W'(1);
        bus.imem_en   = in_run;
        bus.imem_addr = in_run ? fetch_addr : '0;
        bus.instr     = inflight ? bus.imem_rdata : '0;
        bus.instr_pc  = issued_addr;
        done          = (state == HALT);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next state; a redirect suppresses acceptance, so it also blocks HALT.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, HALT: if (start) state_nxt = RUN;
            RUN:        if (!redirect && at_last) state_nxt = HALT;
            default:    state_nxt = IDLE;
        endcase
    end

    // Fetch pointer, issued-address register and inflight flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= '0;
            issued_addr <= '0;
            inflight    <= 1'b0;
        end else if (launch) begin
            pc       <= '0;
            inflight <= 1'b0;
        end else if (in_run) begin
            if (redirect) begin
                pc       <= bus.redirect_target;
                inflight <= 1'b0;
            end else if (at_last) begin
                inflight <= 1'b0;
            end else begin
                pc          <= fetch_addr;
                issued_addr <= fetch_addr;
                inflight    <= 1'b1;
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] count_q;

    // Accepted-instruction counter; cleared on launch, saturates at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count_q <= '0;
        else if (launch)
            count_q <= '0;
        else if (accept && count_q != 16'hFFFF)
            count_q <= count_q + 16'd1;
    end

    assign instr_count = count_q;
`else
    assign instr_count = 16'd0;
`endif
endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: cycle table for the main program flow
// plus hand sequences for mid-run reset and 4-bit PC wrap.
module tb_instr_fetch;
`ifdef FETCH_PERF_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        start, start4;
    logic [9:0]  last_pc;
    logic [3:0]  last_pc4;
    logic        done, done4;
    logic [15:0] instr_count, instr_count4;

    int nvec = 0;
    int nerr = 0;

    instr_fetch_if #(.PC_W(10), .IW(9)) bus ();
    instr_fetch_if #(.PC_W(4),  .IW(9)) bus4 ();

    instr_fetch #(.PC_W(10), .IW(9)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .last_pc(last_pc),
        .done(done), .instr_count(instr_count), .bus(bus)
    );

    instr_fetch #(.PC_W(4), .IW(9)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .last_pc(last_pc4),
        .done(done4), .instr_count(instr_count4), .bus(bus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [8:0] rom(input logic [9:0] a);
        return 9'((a * 3) + 5);
    endfunction

    function automatic logic [8:0] rom4(input logic [3:0] a);
        return {5'd0, a} ^ 9'h0A5;
    endfunction

    always @(posedge clk) if (bus.imem_en)  bus.imem_rdata  <= rom(bus.imem_addr);
    always @(posedge clk) if (bus4.imem_en) bus4.imem_rdata <= rom4(bus4.imem_addr);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic       st;
        logic       dr;
        logic       rv;
        logic [9:0] tgt;
        logic [9:0] last;
        logic       en;
        logic       valid;
        logic [9:0] pc;
        logic [9:0] addr;
        logic       dn;
        int         cnt;
    } vec_t;

    vec_t vt[28];

    function automatic vec_t mk(input logic st, dr, rv, input logic [9:0] tgt, last,
                                input logic en, valid, input logic [9:0] pc, addr,
                                input logic dn, input int cnt);
        vec_t v;
        v.st = st; v.dr = dr; v.rv = rv; v.tgt = tgt; v.last = last;
        v.en = en; v.valid = valid; v.pc = pc; v.addr = addr; v.dn = dn; v.cnt = cnt;
        return v;
    endfunction

    initial begin
        //          st dr rv tgt     last     en vl pc      addr    dn cnt
        vt[0]  = mk(1, 1, 0, 10'h0,  10'd3,   0, 0, 10'h0,  10'h0,  0, 0);
        vt[1]  = mk(0, 1, 0, 10'h0,  10'd3,   1, 0, 10'h0,  10'h0,  0, 0);
        vt[2]  = mk(0, 1, 0, 10'h0,  10'd3,   1, 1, 10'h0,  10'h1,  0, 0);
        vt[3]  = mk(0, 1, 0, 10'h0,  10'd3,   1, 1, 10'h1,  10'h2,  0, 1);
        vt[4]  = mk(0, 1, 0, 10'h0,  10'd3,   1, 1, 10'h2,  10'h3,  0, 2);
        vt[5]  = mk(0, 1, 0, 10'h0,  10'd3,   1, 1, 10'h3,  10'h4,  0, 3);
        vt[6]  = mk(0, 1, 0, 10'h0,  10'd3,   0, 0, 10'h0,  10'h0,  1, 4);
        vt[7]  = mk(0, 1, 1, 10'h55, 10'd3,   0, 0, 10'h0,  10'h0,  1, 4);
        vt[8]  = mk(1, 1, 0, 10'h0,  10'd20,  0, 0, 10'h0,  10'h0,  1, 4);
        vt[9]  = mk(0, 1, 0, 10'h0,  10'd20,  1, 0, 10'h0,  10'h0,  0, 0);
        vt[10] = mk(0, 1, 0, 10'h0,  10'd20,  1, 1, 10'h0,  10'h1,  0, 0);
        vt[11] = mk(0, 1, 0, 10'h0,  10'd20,  1, 1, 10'h1,  10'h2,  0, 1);
        vt[12] = mk(0, 1, 0, 10'h0,  10'd20,  1, 1, 10'h2,  10'h3,  0, 2);
        vt[13] = mk(0, 1, 0, 10'h0,  10'd20,  1, 1, 10'h3,  10'h4,  0, 3);
        vt[14] = mk(0, 1, 0, 10'h0,  10'd20,  1, 1, 10'h4,  10'h5,  0, 4);
        vt[15] = mk(0, 0, 0, 10'h0,  10'd20,  1, 1, 10'h5,  10'h5,  0, 5);
        vt[16] = mk(1, 0, 0, 10'h0,  10'd20,  1, 1, 10'h5,  10'h5,  0, 5);
        vt[17] = mk(0, 0, 0, 10'h0,  10'd20,  1, 1, 10'h5,  10'h5,  0, 5);
        vt[18] = mk(0, 1, 0, 10'h0,  10'd20,  1, 1, 10'h5,  10'h6,  0, 5);
        vt[19] = mk(0, 1, 0, 10'h0,  10'd20,  1, 1, 10'h6,  10'h7,  0, 6);
        vt[20] = mk(0, 1, 1, 10'h40, 10'd20,  1, 0, 10'h0,  10'h7,  0, 7);
        vt[21] = mk(0, 1, 0, 10'h0,  10'd20,  1, 0, 10'h0,  10'h40, 0, 7);
        vt[22] = mk(0, 1, 0, 10'h0,  10'd20,  1, 1, 10'h40, 10'h41, 0, 7);
        vt[23] = mk(0, 1, 1, 10'h10, 10'h41,  1, 0, 10'h0,  10'h41, 0, 8);
        vt[24] = mk(0, 1, 0, 10'h0,  10'h11,  1, 0, 10'h0,  10'h10, 0, 8);
        vt[25] = mk(0, 1, 0, 10'h0,  10'h11,  1, 1, 10'h10, 10'h11, 0, 8);
        vt[26] = mk(0, 1, 0, 10'h0,  10'h11,  1, 1, 10'h11, 10'h12, 0, 9);
        vt[27] = mk(0, 1, 0, 10'h0,  10'h11,  0, 0, 10'h0,  10'h0,  1, 10);

        rst_n = 1'b0;
        start = 1'b0; last_pc = '0;
        bus.decode_ready = 1'b1; bus.redirect_valid = 1'b0; bus.redirect_target = '0;
        start4 = 1'b0; last_pc4 = 4'd1;
        bus4.decode_ready = 1'b1; bus4.redirect_valid = 1'b0; bus4.redirect_target = '0;

        repeat (2) @(negedge clk);
        #2;
        chk("rst imem_en",     32'(bus.imem_en),     32'd0);
        chk("rst imem_addr",   32'(bus.imem_addr),   32'd0);
        chk("rst instr_valid", 32'(bus.instr_valid), 32'd0);
        chk("rst instr",       32'(bus.instr),       32'd0);
        chk("rst instr_pc",    32'(bus.instr_pc),    32'd0);
        chk("rst done",        32'(done),            32'd0);
        chk("rst instr_count", 32'(instr_count),     32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 28; i++) begin
            @(negedge clk);
            start = vt[i].st;
            bus.decode_ready = vt[i].dr;
            bus.redirect_valid = vt[i].rv;
            bus.redirect_target = vt[i].tgt;
            last_pc = vt[i].last;
            #2;
            chk($sformatf("v%0d imem_en", i),     32'(bus.imem_en),     32'(vt[i].en));
            chk($sformatf("v%0d imem_addr", i),   32'(bus.imem_addr),   32'(vt[i].addr));
            chk($sformatf("v%0d instr_valid", i), 32'(bus.instr_valid), 32'(vt[i].valid));
            chk($sformatf("v%0d done", i),        32'(done),            32'(vt[i].dn));
            chk($sformatf("v%0d instr_count", i), 32'(instr_count),     CNT_ON ? 32'(vt[i].cnt) : 32'd0);
            if (vt[i].valid) begin
                chk($sformatf("v%0d instr_pc", i), 32'(bus.instr_pc), 32'(vt[i].pc));
                chk($sformatf("v%0d instr", i),    32'(bus.instr),    32'(rom(vt[i].pc)));
            end
        end

        // Mid-run reset, then restart from address 0 with a fresh count.
        @(negedge clk);
        start = 1'b1; last_pc = 10'd100;
        bus.decode_ready = 1'b1; bus.redirect_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        chk("pre-rst instr_valid", 32'(bus.instr_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst imem_en",     32'(bus.imem_en),     32'd0);
        chk("midrst imem_addr",   32'(bus.imem_addr),   32'd0);
        chk("midrst instr_valid", 32'(bus.instr_valid), 32'd0);
        chk("midrst instr",       32'(bus.instr),       32'd0);
        chk("midrst instr_pc",    32'(bus.instr_pc),    32'd0);
        chk("midrst done",        32'(done),            32'd0);
        chk("midrst instr_count", 32'(instr_count),     32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #2;
        chk("restart issue addr", 32'(bus.imem_addr), 32'd0);
        @(negedge clk);
        #2;
        chk("restart instr_valid", 32'(bus.instr_valid), 32'd1);
        chk("restart instr_pc",    32'(bus.instr_pc),    32'd0);
        @(negedge clk);
        #2;
        chk("restart instr_pc+1",  32'(bus.instr_pc),    32'd1);
        chk("restart instr_count", 32'(instr_count),     CNT_ON ? 32'd1 : 32'd0);

        // 4-bit PC: redirect to 14 right after start, expect 14,15,0,1 then done.
        @(negedge clk);
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        bus4.redirect_valid = 1'b1; bus4.redirect_target = 4'd14;
        #2;
        chk("w4 redirect valid", 32'(bus4.instr_valid), 32'd0);
        @(negedge clk);
        bus4.redirect_valid = 1'b0;
        #2;
        chk("w4 issue addr", 32'(bus4.imem_addr), 32'd14);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #2;
            chk($sformatf("w4 c%0d instr_valid", k), 32'(bus4.instr_valid), 32'd1);
            chk($sformatf("w4 c%0d instr_pc", k),    32'(bus4.instr_pc),    32'((14 + k) % 16));
            chk($sformatf("w4 c%0d instr", k),       32'(bus4.instr),       32'(rom4(4'((14 + k) % 16))));
            chk($sformatf("w4 c%0d done", k),        32'(done4),            32'd0);
        end
        @(negedge clk);
        #2;
        chk("w4 done",        32'(done4),            32'd1);
        chk("w4 imem_en off", 32'(bus4.imem_en),     32'd0);
        chk("w4 valid off",   32'(bus4.instr_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
